median_share_sched: RTL and testbench
=====================================

Name: median_share_sched

Overview:
- Sequences and time-shares one clocked median-of-three unit (`median`: word0/word1/word2 in, median_word out, active-low rst_n) among NREQ independent requesters.
- Runs the unit's power-up reset sequence, then arbitrates round-robin, issuing at most one triple per cycle.
- Tracks each issued operation through the unit's fixed latency and routes the result back to the requester that issued it.
- Sits between HLS-generated filter kernels and a single shared median instance, so one median unit serves several filter channels.

Parameters:
- NREQ, 3, number of requesters (2..8)
- WIDTH, 32, data word width
- LAT, 1, median unit latency in cycles from word inputs to median_word (1..4)
- CNTW, 16, width of completed-operation counter

Ports:
- clk  input  1  clock
- rst  input  1  reset
- req_valid  input  NREQ  per-requester triple valid
- req_ready  output  NREQ  per-requester accept (one-hot or zero)
- req_w0  input  NREQ*WIDTH  word0 per requester; requester i occupies bits [i*WIDTH +: WIDTH]
- req_w1  input  NREQ*WIDTH  word1, same packing
- req_w2  input  NREQ*WIDTH  word2, same packing
- resp_valid  output  NREQ  one-cycle result pulse, one-hot or zero
- resp_data  output  WIDTH  median result, valid with resp_valid
- m_rst_n  output  1  to median unit rst_n
- m_word0 / m_word1 / m_word2  output  WIDTH each  to median unit word inputs
- m_median_word  input  WIDTH  from median unit
- init_done  output  1  high once state RUN is reached
- done_count  output  CNTW  completed operations, wraps modulo 2^CNTW

Behaviour:
- Reset is synchronous and active-high on rst; clock is clk.
- While rst is high:
  - state = INIT_A, rr_ptr = 0, in-flight pipeline cleared, done_count = 0.
  - m_rst_n = 0, req_ready = 0, resp_valid = 0, init_done = 0, m_word* = 0.
- State machine, one cycle per init state:
  - INIT_A: m_rst_n = 1; next state INIT_B.
  - INIT_B: m_rst_n = 0; next state INIT_C.
  - INIT_C: m_rst_n = 1; next state RUN.
  - RUN: m_rst_n = 1, init_done = 1; state is absorbing.
- Outside RUN: req_ready = 0 regardless of req_valid, and nothing is issued.
- Arbitration, combinational, RUN only:
  - Grant the first i with req_valid[i] = 1, scanning rr_ptr, rr_ptr+1, … modulo NREQ.
  - req_ready[grant] = 1; all other req_ready bits = 0.
  - If no request is valid, no grant and req_ready = 0.
  - req_ready may depend on req_valid. Requesters must hold their words stable while valid is high.
- Issue: in a grant cycle, m_word0..2 = the granted requester's words; in non-grant cycles, m_word* = 0.
  - On the clock edge, rr_ptr <= (grant + 1) mod NREQ.
  - rr_ptr is unchanged when there is no grant.
- Tracking: a LAT-deep shift register carries {valid, id} for every cycle.
  - Entry enters on the issue cycle.
  - When the entry exits, LAT cycles after issue, resp_valid[id] = 1 and resp_data = m_median_word.
- Throughput: one issue per cycle sustained. Back-to-back results come from different or the same requesters in issue order.
- resp_data = 0 when no resp_valid bit is set.
- There is no response backpressure; requesters must accept the pulse.
- done_count increments by 1 on each resp_valid pulse and wraps from 2^CNTW-1 to 0.
- Reset mid-operation: all in-flight entries are discarded and no response is emitted for them. The init sequence is re-run before any new grant.
- Invalid LAT (<1 or >4): elaboration error.

Test Plan:
- Init: deassert rst, no requests -> m_rst_n sequence 1,0,1,1…; init_done rises on the 4th cycle after reset; req_valid held high during INIT_* -> req_ready = 0 until RUN.
- Single requester, LAT=1: req 1 issues (5,9,7) -> m_word* = 5,9,7 in the grant cycle; resp_valid = 3'b010, resp_data = 7 one cycle later; done_count = 1.
- Contention, NREQ=3, all valid continuously with distinct triples -> grants 0,1,2,0,1,2…; responses in the same order with correct medians, e.g. (1,2,3) -> 2, (30,10,20) -> 20, (4,4,9) -> 4.
- Pointer fairness: only req 2 valid for 2 grants, then reqs 0 and 2 valid -> next grant 0, then 2.
- Pipeline, LAT=3: 6 back-to-back issues -> 6 consecutive resp_valid pulses starting 3 cycles after the first grant, with ids and data matching issue order.
- Reset mid-flight, LAT=3: issue 2 ops, assert rst the next cycle for 1 cycle -> no resp_valid pulses; done_count = 0; init sequence repeats; subsequent operation completes normally.

Source files
------------

// File: rtl/median_share_sched.sv
// rtl/median_share_sched.sv - round-robin time-sharing of one pipelined median-of-three unit
module median_share_sched #(
  parameter int NREQ  = 3,
  parameter int WIDTH = 32,
  parameter int LAT   = 1,
  parameter int CNTW  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_w0,
  input  logic [NREQ*WIDTH-1:0] req_w1,
  input  logic [NREQ*WIDTH-1:0] req_w2,
  output logic [NREQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]      resp_data,
  output logic                  m_rst_n,
  output logic [WIDTH-1:0]      m_word0,
  output logic [WIDTH-1:0]      m_word1,
  output logic [WIDTH-1:0]      m_word2,
  input  logic [WIDTH-1:0]      m_median_word,
  output logic                  init_done,
  output logic [CNTW-1:0]       done_count
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  generate
    if (LAT < 1 || LAT > 4) begin : g_bad_lat
      $error("median_share_sched: LAT must be in 1..4");
    end
    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
      $error("median_share_sched: NREQ must be in 2..8");
    end
  endgenerate

  typedef enum logic [1:0] {
    INIT_A = 2'd0,
    INIT_B = 2'd1,
    INIT_C = 2'd2,
    RUN    = 2'd3
  } state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   next_ptr;
  logic            grant_v;
  logic [PW-1:0]   grant_id;
  int              idx;
  logic [LAT-1:0]  pipe_v;
  logic [PW-1:0]   pipe_id [LAT];
  logic            resp_fire;
  logic [CNTW-1:0] cnt;

  // Round-robin search starting at rr_ptr; only in RUN and never while reset is held
  always_comb begin
    grant_v  = 1'b0;
    grant_id = '0;
    idx      = 0;
    if (!rst && state == RUN) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(rr_ptr) + k) % NREQ;
        if (!grant_v && req_valid[idx]) begin
          grant_v  = 1'b1;
          grant_id = PW'(idx);
        end
      end
    end
  end

  // Pointer moves to the requester after the one just served
  always_comb begin
    next_ptr = (grant_id == PW'(NREQ - 1)) ? '0 : grant_id + PW'(1);
  end

  // Grant decode and word mux toward the median unit; idle cycles drive zeros
  always_comb begin
    req_ready = '0;
    m_word0   = '0;
    m_word1   = '0;
    m_word2   = '0;
    if (grant_v) begin
      req_ready = NREQ'(1) << grant_id;
      m_word0   = req_w0[int'(grant_id)*WIDTH +: WIDTH];
      m_word1   = req_w1[int'(grant_id)*WIDTH +: WIDTH];
      m_word2   = req_w2[int'(grant_id)*WIDTH +: WIDTH];
    end
  end

  // Init sequence pulses the unit's reset low for one cycle, then RUN is absorbing
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= INIT_A;
      rr_ptr <= '0;
    end else begin
      case (state)
        INIT_A:  state <= INIT_B;
        INIT_B:  state <= INIT_C;
        INIT_C:  state <= RUN;
        default: state <= RUN;
      endcase
      if (grant_v) rr_ptr <= next_ptr;
    end
  end

  // Outputs decoded from state; reset forces the unit into reset immediately
  always_comb begin
    m_rst_n   = !rst && (state != INIT_B);
    init_done = !rst && (state == RUN);
  end

  // Issue tracker: one {valid, id} entry per cycle, exiting when the unit's result appears
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v <= '0;
      for (int k = 0; k < LAT; k++) pipe_id[k] <= '0;
    end else begin
      pipe_v[0]  <= grant_v;
      pipe_id[0] <= grant_id;
      for (int k = 1; k < LAT; k++) begin
        pipe_v[k]  <= pipe_v[k-1];
        pipe_id[k] <= pipe_id[k-1];
      end
    end
  end

  // Route the exiting result to its requester; in-flight work is dropped while rst is high
  always_comb begin
    resp_fire  = !rst && pipe_v[LAT-1];
    resp_valid = resp_fire ? (NREQ'(1) << pipe_id[LAT-1]) : '0;
    resp_data  = resp_fire ? m_median_word : '0;
  end

  // Completed-operation counter, wraps naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (resp_fire) begin
      cnt <= cnt + CNTW'(1);
    end
  end

  // Counter reads as zero for the whole reset window
  always_comb begin
    done_count = rst ? '0 : cnt;
  end

endmodule

// File: tb/tb_median_share_sched.sv
// tb/tb_median_share_sched.sv - directed vector bench for median_share_sched (LAT=1 and LAT=3 instances)
module tb_median_share_sched;

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid;
  logic [95:0] req_w0, req_w1, req_w2;

  logic [2:0]  ready_a, ready_b, rv_a, rv_b;
  logic [31:0] rd_a, rd_b;
  logic        mrst_a, mrst_b, init_a, init_b;
  logic [31:0] mw0_a, mw1_a, mw2_a, mw0_b, mw1_b, mw2_b;
  logic [31:0] med_a, md_b [3];
  logic [2:0]  cnt_a;
  logic [15:0] cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  median_share_sched #(.NREQ(3), .WIDTH(32), .LAT(1), .CNTW(3)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_a),
    .req_w0(req_w0), .req_w1(req_w1), .req_w2(req_w2),
    .resp_valid(rv_a), .resp_data(rd_a), .m_rst_n(mrst_a),
    .m_word0(mw0_a), .m_word1(mw1_a), .m_word2(mw2_a),
    .m_median_word(med_a), .init_done(init_a), .done_count(cnt_a)
  );

  median_share_sched #(.NREQ(3), .WIDTH(32), .LAT(3), .CNTW(16)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_b),
    .req_w0(req_w0), .req_w1(req_w1), .req_w2(req_w2),
    .resp_valid(rv_b), .resp_data(rd_b), .m_rst_n(mrst_b),
    .m_word0(mw0_b), .m_word1(mw1_b), .m_word2(mw2_b),
    .m_median_word(md_b[2]), .init_done(init_b), .done_count(cnt_b)
  );

  function automatic logic [31:0] med3(input logic [31:0] a, b, c);
    logic [31:0] lo, hi;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    if (c <= lo) return lo;
    if (c >= hi) return hi;
    return c;
  endfunction

  // Stand-in median units with latency 1 and 3
  always @(posedge clk) begin
    if (!mrst_a) med_a <= '0;
    else         med_a <= med3(mw0_a, mw1_a, mw2_a);
  end

  always @(posedge clk) begin
    if (!mrst_b) begin
      md_b[0] <= '0; md_b[1] <= '0; md_b[2] <= '0;
    end else begin
      md_b[0] <= med3(mw0_b, mw1_b, mw2_b);
      md_b[1] <= md_b[0];
      md_b[2] <= md_b[1];
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic             rst;
    logic [2:0]       v;
    logic [8:0][31:0] w;
    logic [2:0]       er;
    logic [31:0]      em;
    logic             mr;
    logic             idn;
  } vec_t;

  typedef struct packed {
    logic [2:0]  oh;
    logic [31:0] d;
  } rsp_t;

  vec_t        vecs[$];
  rsp_t        pa;
  rsp_t        pb [3];
  int unsigned ecnt_a, ecnt_b;

  task automatic add(input logic r, input logic [2:0] v,
                     input logic [31:0] a0, a1, a2, b0, b1, b2, c0, c1, c2,
                     input logic [2:0] er, input logic [31:0] em,
                     input logic mr, input logic idn);
    vec_t t;
    t.rst = r; t.v = v;
    t.w[0] = a0; t.w[1] = a1; t.w[2] = a2;
    t.w[3] = b0; t.w[4] = b1; t.w[5] = b2;
    t.w[6] = c0; t.w[7] = c1; t.w[8] = c2;
    t.er = er; t.em = em; t.mr = mr; t.idn = idn;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input int n, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0h, expected %0h", name, n, act, exp);
    end
  endtask

  task automatic step(input vec_t t, input int n);
    rsp_t        ea, eb, nw;
    logic [95:0] ew;
    int          gi;
    @(posedge clk);
    #1;
    rst       = t.rst;
    req_valid = t.v;
    for (int i = 0; i < 3; i++) begin
      req_w0[i*32 +: 32] = t.w[i*3];
      req_w1[i*32 +: 32] = t.w[i*3+1];
      req_w2[i*32 +: 32] = t.w[i*3+2];
    end
    @(negedge clk);
    case (t.er)
      3'b001:  gi = 0;
      3'b010:  gi = 1;
      3'b100:  gi = 2;
      default: gi = -1;
    endcase
    ew = (gi < 0) ? 96'd0 : {t.w[gi*3], t.w[gi*3+1], t.w[gi*3+2]};
    ea = t.rst ? '0 : pa;
    eb = t.rst ? '0 : pb[2];
    chk("ready_a", n, 96'(ready_a), 96'(t.er));
    chk("ready_b", n, 96'(ready_b), 96'(t.er));
    chk("words_a", n, {mw0_a, mw1_a, mw2_a}, ew);
    chk("words_b", n, {mw0_b, mw1_b, mw2_b}, ew);
    chk("m_rst_n_a", n, 96'(mrst_a), 96'(t.mr));
    chk("m_rst_n_b", n, 96'(mrst_b), 96'(t.mr));
    chk("init_done_a", n, 96'(init_a), 96'(t.idn));
    chk("init_done_b", n, 96'(init_b), 96'(t.idn));
    chk("resp_valid_a", n, 96'(rv_a), 96'(ea.oh));
    chk("resp_valid_b", n, 96'(rv_b), 96'(eb.oh));
    chk("resp_data_a", n, 96'(rd_a), 96'(ea.d));
    chk("resp_data_b", n, 96'(rd_b), 96'(eb.d));
    chk("done_count_a", n, 96'(cnt_a), t.rst ? 96'd0 : 96'(ecnt_a % 8));
    chk("done_count_b", n, 96'(cnt_b), t.rst ? 96'd0 : 96'(ecnt_b % 65536));
    if (t.rst) begin
      pa = '0; pb[0] = '0; pb[1] = '0; pb[2] = '0;
      ecnt_a = 0; ecnt_b = 0;
    end else begin
      if (ea.oh != 3'b000) ecnt_a++;
      if (eb.oh != 3'b000) ecnt_b++;
      nw.oh = t.er;
      nw.d  = (t.er != 3'b000) ? t.em : 32'd0;
      pb[2] = pb[1]; pb[1] = pb[0]; pb[0] = nw;
      pa    = nw;
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_w0 = '0; req_w1 = '0; req_w2 = '0;
    pa = '0; pb[0] = '0; pb[1] = '0; pb[2] = '0; ecnt_a = 0; ecnt_b = 0;

    // reset held with requests pending, then the init sequence with requests still pending
    for (int k = 0; k < 2; k++) add(1, 3'b111, 1,2,3, 30,10,20, 4,4,9, 3'b000, 0, 0, 0);
    add(0, 3'b111, 1,2,3, 30,10,20, 4,4,9, 3'b000, 0, 1, 0);
    add(0, 3'b111, 1,2,3, 30,10,20, 4,4,9, 3'b000, 0, 0, 0);
    add(0, 3'b111, 1,2,3, 30,10,20, 4,4,9, 3'b000, 0, 1, 0);
    // contention: grants rotate 0,1,2
    for (int k = 0; k < 2; k++) begin
      add(0, 3'b111, 1,2,3, 30,10,20, 4,4,9, 3'b001, 2, 1, 1);
      add(0, 3'b111, 1,2,3, 30,10,20, 4,4,9, 3'b010, 20, 1, 1);
      add(0, 3'b111, 1,2,3, 30,10,20, 4,4,9, 3'b100, 4, 1, 1);
    end
    for (int k = 0; k < 3; k++) add(0, 3'b000, 0,0,0, 0,0,0, 0,0,0, 3'b000, 0, 1, 1);
    // single requester 1
    add(0, 3'b010, 0,0,0, 5,9,7, 0,0,0, 3'b010, 7, 1, 1);
    for (int k = 0; k < 3; k++) add(0, 3'b000, 0,0,0, 0,0,0, 0,0,0, 3'b000, 0, 1, 1);
    // pointer fairness: req 2 alone twice, then 0 and 2 compete
    add(0, 3'b100, 0,0,0, 0,0,0, 11,33,22, 3'b100, 22, 1, 1);
    add(0, 3'b100, 0,0,0, 0,0,0, 8,6,7, 3'b100, 7, 1, 1);
    add(0, 3'b101, 100,50,75, 0,0,0, 3,1,2, 3'b001, 75, 1, 1);
    add(0, 3'b101, 9,9,9, 0,0,0, 3,1,2, 3'b100, 2, 1, 1);
    for (int k = 0; k < 3; k++) add(0, 3'b000, 0,0,0, 0,0,0, 0,0,0, 3'b000, 0, 1, 1);
    // six back-to-back issues
    for (int k = 0; k < 2; k++) begin
      add(0, 3'b111, 1,2,3, 30,10,20, 4,4,9, 3'b001, 2, 1, 1);
      add(0, 3'b111, 1,2,3, 30,10,20, 4,4,9, 3'b010, 20, 1, 1);
      add(0, 3'b111, 1,2,3, 30,10,20, 4,4,9, 3'b100, 4, 1, 1);
    end
    for (int k = 0; k < 3; k++) add(0, 3'b000, 0,0,0, 0,0,0, 0,0,0, 3'b000, 0, 1, 1);

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

    // reset mid-flight: two issues, one reset cycle, init reruns, pointer restarts at 0
    vecs.delete();
    add(0, 3'b001, 7,8,9, 0,0,0, 0,0,0, 3'b001, 8, 1, 1);
    add(0, 3'b010, 0,0,0, 2,1,3, 0,0,0, 3'b010, 2, 1, 1);
    add(1, 3'b000, 0,0,0, 0,0,0, 0,0,0, 3'b000, 0, 0, 0);
    add(0, 3'b110, 0,0,0, 2,1,3, 4,4,9, 3'b000, 0, 1, 0);
    add(0, 3'b110, 0,0,0, 2,1,3, 4,4,9, 3'b000, 0, 0, 0);
    add(0, 3'b110, 0,0,0, 2,1,3, 4,4,9, 3'b000, 0, 1, 0);
    add(0, 3'b110, 0,0,0, 2,1,3, 4,4,9, 3'b010, 2, 1, 1);
    add(0, 3'b100, 0,0,0, 0,0,0, 4,4,9, 3'b100, 4, 1, 1);
    for (int k = 0; k < 4; k++) add(0, 3'b000, 0,0,0, 0,0,0, 0,0,0, 3'b000, 0, 1, 1);
    for (int i = 0; i < vecs.size(); i++) step(vecs[i], 100 + i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
